// File: rtl/ifu_icache_req_sched_if.sv
// Bundle of demand/prefetch request, icache lookup/response and status signals
// around the icache request scheduler.
interface ifu_icache_req_sched_if #(
    parameter int PC_WIDTH = 64,
    parameter int ID_WIDTH = 2
);
    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid must not depend on ready, and dmd_rdy/pf_rdy report the transfer itself.
    logic                flush;
    logic                dmd_vld;
    logic [PC_WIDTH-1:0] dmd_pc;
    logic                dmd_rdy;
    logic                pf_vld;
    logic [PC_WIDTH-1:0] pf_pc;
    logic                pf_rdy;
    logic                ic_req_vld;
    logic [PC_WIDTH-1:0] ic_req_pc;
    logic [ID_WIDTH-1:0] ic_req_id;
    logic                ic_req_pf;
    logic                ic_req_rdy;
    logic                ic_rsp_vld;
    logic [ID_WIDTH-1:0] ic_rsp_id;
    logic                rsp_vld;
    logic [ID_WIDTH-1:0] rsp_id;
    logic                rsp_pf;
    logic [ID_WIDTH:0]   outstanding;
    logic                err;

    modport master (
        output flush, dmd_vld, dmd_pc, pf_vld, pf_pc, ic_req_rdy, ic_rsp_vld, ic_rsp_id,
        input  dmd_rdy, pf_rdy, ic_req_vld, ic_req_pc, ic_req_id, ic_req_pf,
               rsp_vld, rsp_id, rsp_pf, outstanding, err
    );

    modport slave (
        input  flush, dmd_vld, dmd_pc, pf_vld, pf_pc, ic_req_rdy, ic_rsp_vld, ic_rsp_id,
        output dmd_rdy, pf_rdy, ic_req_vld, ic_req_pc, ic_req_id, ic_req_pf,
               rsp_vld, rsp_id, rsp_pf, outstanding, err
    );
endinterface

// File: rtl/ifu_icache_req_sched.sv
// Arbitrates demand fetch vs next-line prefetch onto one icache lookup port,
// tracks outstanding IDs and drops responses from a pre-redirect epoch.
module ifu_icache_req_sched #(
    parameter int PC_WIDTH     = 64,
    parameter int NUM_ID       = 4,
    parameter int ID_WIDTH     = 2,
    parameter int STARVE_LIMIT = 3
) (
    input logic                   clk,
    input logic                   rst,
    ifu_icache_req_sched_if.slave bus
);
    localparam int CW = ID_WIDTH + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [NUM_ID-1:0]   slot_vld;
    logic [NUM_ID-1:0]   slot_ep;
    logic [NUM_ID-1:0]   slot_pf;
    logic                epoch;
    logic [SW-1:0]       starve_cnt;
    logic [SW-1:0]       starve_nxt;
    logic                err_q;
    logic                rsp_vld_q;
    logic [ID_WIDTH-1:0] rsp_id_q;
    logic                rsp_pf_q;

    logic [CW-1:0]       n_valid;
    logic [CW-1:0]       n_free;
    logic                free_found;
    logic [ID_WIDTH-1:0] free_id;
    logic                dmd_elig;
    logic                pf_elig;
    logic                pf_win;
    logic                req_vld;
    logic                fire;
    logic                rsp_hit;

    // Allocation looks only at registered slots, so a slot freed this cycle waits a cycle.
    always_comb begin
        n_valid    = '0;
        free_found = 1'b0;
        free_id    = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            if (slot_vld[i]) begin
                n_valid = n_valid + CW'(1);
            end else if (!free_found) begin
                free_found = 1'b1;
                free_id    = ID_WIDTH'(i);
            end
        end
    end

    assign n_free   = CW'(NUM_ID) - n_valid;
    assign dmd_elig = bus.dmd_vld & free_found;
    // Prefetch always leaves the last free slot for demand.
    assign pf_elig  = bus.pf_vld & (n_free >= CW'(2));
    assign pf_win   = pf_elig & (~dmd_elig | (starve_cnt == SW'(STARVE_LIMIT)));
    assign req_vld  = ~rst & ~bus.flush & (dmd_elig | pf_elig);
    assign fire     = req_vld & bus.ic_req_rdy;
    assign rsp_hit  = bus.ic_rsp_vld & slot_vld[bus.ic_rsp_id] &
                      (slot_ep[bus.ic_rsp_id] == epoch) & ~bus.flush;

    always_comb begin
        starve_nxt = starve_cnt;
        if (!bus.pf_vld) begin
            starve_nxt = '0;
        end else if (fire && pf_win) begin
            starve_nxt = '0;
        end else if (fire && pf_elig && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld   <= '0;
            slot_ep    <= '0;
            slot_pf    <= '0;
            epoch      <= 1'b0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_pf_q   <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_hit;
            if (rsp_hit) begin
                rsp_id_q <= bus.ic_rsp_id;
                rsp_pf_q <= slot_pf[bus.ic_rsp_id];
            end
            if (bus.ic_rsp_vld) begin
                if (slot_vld[bus.ic_rsp_id]) begin
                    slot_vld[bus.ic_rsp_id] <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            // The fire slot is invalid in registered state, so it never aliases a live response.
            if (fire) begin
                slot_vld[free_id] <= 1'b1;
                slot_ep[free_id]  <= epoch;
                slot_pf[free_id]  <= pf_win;
            end
            if (bus.flush) begin
                epoch <= ~epoch;
            end
            starve_cnt <= starve_nxt;
        end
    end

    assign bus.ic_req_vld  = req_vld;
    assign bus.ic_req_pc   = pf_win ? bus.pf_pc : bus.dmd_pc;
    assign bus.ic_req_id   = free_id;
    assign bus.ic_req_pf   = pf_win;
    assign bus.dmd_rdy     = fire & ~pf_win;
    assign bus.pf_rdy      = fire & pf_win;
    assign bus.rsp_vld     = rsp_vld_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_pf      = rsp_pf_q;
    assign bus.outstanding = n_valid;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ifu_icache_req_sched.sv
// Bench for ifu_icache_req_sched: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based model of the slot pool.
module tb_ifu_icache_req_sched;
    localparam int PC_WIDTH     = 64;
    localparam int NUM_ID       = 4;
    localparam int ID_WIDTH     = 2;
    localparam int STARVE_LIMIT = 3;

    logic clk;
    logic rst;

    ifu_icache_req_sched_if #(.PC_WIDTH(PC_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

    ifu_icache_req_sched #(
        .PC_WIDTH(PC_WIDTH), .NUM_ID(NUM_ID), .ID_WIDTH(ID_WIDTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: outstanding requests as a list of {id, epoch, pf}
    typedef struct {
        int id;
        bit ep;
        bit pf;
    } slot_t;

    slot_t      mq[$];
    logic [2:0] exp_q[$];
    bit         m_epoch;
    int         m_starve;
    bit         m_err;
    bit         last_fire;
    int         last_fire_id;
    bit         last_pf_rdy;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find_slot(input int id);
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].id == id) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_epoch  = 1'b0;
        m_starve = 0;
        m_err    = 1'b0;
    endtask

    // One clock: check the current cycle against the model, then advance the model.
    task automatic tick();
        int         nfree;
        int         fid;
        int         idx;
        bit         de, pe, pwin, req, fire;
        bit         s_rst, s_flush, s_pfv, s_rspv;
        int         s_rspid;
        logic [2:0] e;
        #4;
        nfree = NUM_ID - mq.size();
        fid   = -1;
        for (int i = 0; i < NUM_ID; i++) begin
            if (fid < 0 && find_slot(i) < 0) fid = i;
        end
        de   = bus.dmd_vld && (nfree >= 1);
        pe   = bus.pf_vld && (nfree >= 2);
        pwin = pe && (!de || m_starve == STARVE_LIMIT);
        req  = !rst && !bus.flush && (de || pe);
        fire = req && bus.ic_req_rdy;

        check("ic_req_vld", bus.ic_req_vld, req);
        if (req) begin
            check("ic_req_pc", bus.ic_req_pc, pwin ? bus.pf_pc : bus.dmd_pc);
            check("ic_req_id", bus.ic_req_id, fid);
            check("ic_req_pf", bus.ic_req_pf, pwin);
        end
        check("dmd_rdy", bus.dmd_rdy, fire && !pwin);
        check("pf_rdy", bus.pf_rdy, fire && pwin);
        check("outstanding", bus.outstanding, mq.size());
        check("err", bus.err, m_err);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_vld", bus.rsp_vld, 1);
            check("rsp_id", bus.rsp_id, e[1:0]);
            check("rsp_pf", bus.rsp_pf, e[2]);
        end else begin
            check("rsp_vld", bus.rsp_vld, 0);
        end

        last_fire    = fire;
        last_fire_id = fid;
        last_pf_rdy  = bus.pf_rdy;
        s_rst   = rst;
        s_flush = bus.flush;
        s_pfv   = bus.pf_vld;
        s_rspv  = bus.ic_rsp_vld;
        s_rspid = int'(bus.ic_rsp_id);

        @(posedge clk);
        if (s_rst) begin
            model_reset();
        end else begin
            if (s_rspv) begin
                idx = find_slot(s_rspid);
                if (idx >= 0) begin
                    if (mq[idx].ep == m_epoch && !s_flush)
                        exp_q.push_back({mq[idx].pf, 2'(s_rspid)});
                    mq.delete(idx);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (fire) mq.push_back('{id: fid, ep: m_epoch, pf: pwin});
            if (!s_pfv || (fire && pwin)) m_starve = 0;
            else if (fire && pe && m_starve < STARVE_LIMIT) m_starve++;
            if (s_flush) m_epoch = ~m_epoch;
        end
        #1;
    endtask

    // driver
    task automatic drv(input bit r, input bit fl, input bit dv, input logic [63:0] dpc,
                       input bit pv, input logic [63:0] ppc, input bit rdy,
                       input bit rv, input int rid);
        rst            = r;
        bus.flush      = fl;
        bus.dmd_vld    = dv;
        bus.dmd_pc     = dpc;
        bus.pf_vld     = pv;
        bus.pf_pc      = ppc;
        bus.ic_req_rdy = rdy;
        bus.ic_rsp_vld = rv;
        bus.ic_rsp_id  = 2'(rid);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < NUM_ID && mq.size() > 0; k++) drv(0, 0, 0, 0, 0, 0, 1, 1, mq[0].id);
        idle(1);
    endtask

    logic [7:0] gpat;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.dmd_vld    = 1'b0;
        bus.dmd_pc     = '0;
        bus.pf_vld     = 1'b0;
        bus.pf_pc      = '0;
        bus.ic_req_rdy = 1'b0;
        bus.ic_rsp_vld = 1'b0;
        bus.ic_rsp_id  = '0;
        model_reset();
        @(posedge clk);
        #1;
        drv(1, 0, 1, 64'h40, 1, 64'h80, 1, 0, 0);
        idle(2);

        // single demand
        drv(0, 0, 1, 64'h1000, 0, 0, 1, 0, 0);
        check("first_outstanding", bus.outstanding, 1);
        idle(1);
        drain();

        // continuous conflict, each response returned the following cycle
        gpat = '0;
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 1, 64'h2000 + 64'(i * 64), 1, 64'h9000 + 64'(i * 64), 1,
                (i > 0) && last_fire, last_fire_id);
            gpat = {gpat[6:0], last_pf_rdy};
        end
        check("grant_pattern", gpat, 8'b0001_0001);
        drv(0, 0, 0, 0, 0, 0, 1, last_fire, last_fire_id);
        drain();

        // fill all slots with demand while prefetch waits for two free slots
        for (int i = 0; i < 4; i++) drv(0, 0, 1, 64'h3000 + 64'(i * 64), 1, 64'hA000, 1, 0, 0);
        check("full_outstanding", bus.outstanding, NUM_ID);
        drv(0, 0, 1, 64'h3100, 1, 64'hA000, 1, 0, 0);
        drain();

        // stale responses after a flush are dropped; new epoch forwards
        drv(0, 0, 1, 64'h4000, 0, 0, 1, 0, 0);
        drv(0, 0, 1, 64'h4040, 0, 0, 1, 0, 0);
        drv(0, 1, 1, 64'h4080, 1, 64'hB000, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1);
        check("stale_drop_cnt", bus.outstanding, 0);
        drv(0, 0, 1, 64'h5000, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(2);

        // response to an unallocated id, then reset clears the sticky error
        drv(0, 0, 0, 0, 0, 0, 1, 1, 2);
        idle(3);
        check("err_sticky", bus.err, 1);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("err_cleared", bus.err, 0);

        // icache stall holds the demand
        for (int i = 0; i < 5; i++) drv(0, 0, 1, 64'h6000, 0, 0, 0, 0, 0);
        check("stall_no_alloc", bus.outstanding, 0);
        drv(0, 0, 1, 64'h6000, 0, 0, 1, 0, 0);
        check("stall_release", bus.outstanding, 1);
        drain();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit rv;
            int rid;
            rv  = ($urandom_range(0, 1) == 1);
            rid = $urandom_range(0, NUM_ID - 1);
            if (mq.size() > 0 && $urandom_range(0, 19) != 0) rid = mq[$urandom_range(0, mq.size() - 1)].id;
            else if ($urandom_range(0, 3) != 0) rv = 1'b0;
            drv($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 7, {$urandom, $urandom},
                $urandom_range(0, 1) == 1, {$urandom, $urandom},
                $urandom_range(0, 9) < 8, rv, rid);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
